// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: word size, default bubble
// encoding, FSM state encoding and small arithmetic helpers.
package fetch_unit_pkg;

    localparam int WORD_SIZE = 16;

    // Instruction word used to fill IF/ID on a flush or bubble.
    localparam logic [WORD_SIZE-1:0] BUBBLE_DEFAULT = 16'hF01C;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

    // PC increment, modulo 2^16: 16'hFFFF wraps to 16'h0000 with no flag.
    function automatic logic [WORD_SIZE-1:0] pc_inc(input logic [WORD_SIZE-1:0] pc);
        return pc + 16'd1;
    endfunction

    // Saturating increment used by the fetch counter.
    function automatic logic [WORD_SIZE-1:0] sat_inc(input logic [WORD_SIZE-1:0] val);
        logic [WORD_SIZE-1:0] res_s;
        if (val == 16'hFFFF) begin
            res_s = val;
        end else begin
            res_s = val + 16'd1;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/fetch_unit_ifid_latch.sv
// IF/ID pipeline register with hold (stall) and flush (bubble) controls.
// Flush replaces the instruction with the bubble word and clears valid
// while the PC fields keep their previous contents.
module ifid_latch
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] BUBBLE_INST = BUBBLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 hold,
    input  logic                 flush,
    input  logic [WORD_SIZE-1:0] load_inst,
    input  logic [WORD_SIZE-1:0] load_pc,
    input  logic [WORD_SIZE-1:0] load_pcplus1,
    output logic [WORD_SIZE-1:0] ifid_inst,
    output logic [WORD_SIZE-1:0] ifid_pc,
    output logic [WORD_SIZE-1:0] ifid_pcplus1,
    output logic                 ifid_valid
);

    logic [WORD_SIZE-1:0] inst_r;
    logic [WORD_SIZE-1:0] pc_r;
    logic [WORD_SIZE-1:0] pcplus1_r;
    logic                 valid_r;

    // IF/ID storage: flush beats hold, hold beats load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inst_r    <= BUBBLE_INST;
            pc_r      <= 16'h0000;
            pcplus1_r <= 16'h0000;
            valid_r   <= 1'b0;
        end else if (flush) begin
            inst_r    <= BUBBLE_INST;
            pc_r      <= pc_r;
            pcplus1_r <= pcplus1_r;
            valid_r   <= 1'b0;
        end else if (hold) begin
            inst_r    <= inst_r;
            pc_r      <= pc_r;
            pcplus1_r <= pcplus1_r;
            valid_r   <= valid_r;
        end else begin
            inst_r    <= load_inst;
            pc_r      <= load_pc;
            pcplus1_r <= load_pcplus1;
            valid_r   <= 1'b1;
        end
    end

    assign ifid_inst    = inst_r;
    assign ifid_pc      = pc_r;
    assign ifid_pcplus1 = pcplus1_r;
    assign ifid_valid   = valid_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, RUN/HALTED FSM, IF/ID latch
// instance and optional fetch counter.
// Optional feature: define FETCH_COUNT_EN to build the saturating count
// of valid fetches on o_num_inst; otherwise o_num_inst is tied to zero.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] RESET_PC    = 16'h0000,
    parameter logic [WORD_SIZE-1:0] BUBBLE_INST = BUBBLE_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic [WORD_SIZE-1:0] o_address1,
    input  logic [WORD_SIZE-1:0] i_inst,
    input  logic                 i_stall,
    input  logic                 i_redirect,
    input  logic [WORD_SIZE-1:0] i_target,
    input  logic                 i_halt,
    output logic [WORD_SIZE-1:0] o_ifid_inst,
    output logic [WORD_SIZE-1:0] o_ifid_pc,
    output logic [WORD_SIZE-1:0] o_ifid_pcplus1,
    output logic                 o_ifid_valid,
    output logic                 o_halted,
    output logic [WORD_SIZE-1:0] o_num_inst
);

    fetch_state_e         state_r;
    fetch_state_e         state_nxt_s;
    logic [WORD_SIZE-1:0] pc_r;
    logic [WORD_SIZE-1:0] pc_nxt_s;
    logic [WORD_SIZE-1:0] pc_plus1_s;
    logic                 halted_r;
    logic                 ifid_hold_s;
    logic                 ifid_flush_s;

    assign pc_plus1_s = pc_inc(pc_r);

    // Next-state decode; priority in RUN is halt > redirect > stall > normal.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        ifid_hold_s  = 1'b0;
        ifid_flush_s = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (i_halt) begin
                    state_nxt_s  = ST_HALTED;
                    ifid_flush_s = 1'b1;
                end else if (i_redirect) begin
                    pc_nxt_s     = i_target;
                    ifid_flush_s = 1'b1;
                end else if (i_stall) begin
                    ifid_hold_s  = 1'b1;
                end else begin
                    pc_nxt_s     = pc_plus1_s;
                end
            end
            ST_HALTED: begin
                ifid_hold_s = 1'b1;
            end
            default: begin
                state_nxt_s = ST_RUN;
                ifid_hold_s = 1'b1;
            end
        endcase
    end

    // FSM, PC and registered halted flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_RUN;
            pc_r     <= RESET_PC;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            halted_r <= (state_nxt_s == ST_HALTED);
        end
    end

    assign o_address1 = pc_r;
    assign o_halted   = halted_r;

    ifid_latch #(
        .BUBBLE_INST (BUBBLE_INST)
    ) u_ifid (
        .clk          (clk),
        .reset_n      (reset_n),
        .hold         (ifid_hold_s),
        .flush        (ifid_flush_s),
        .load_inst    (i_inst),
        .load_pc      (pc_r),
        .load_pcplus1 (pc_plus1_s),
        .ifid_inst    (o_ifid_inst),
        .ifid_pc      (o_ifid_pc),
        .ifid_pcplus1 (o_ifid_pcplus1),
        .ifid_valid   (o_ifid_valid)
    );

`ifdef FETCH_COUNT_EN
    logic [WORD_SIZE-1:0] num_inst_r;

    // Count normal loads into IF/ID, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_inst_r <= 16'h0000;
        end else if (!ifid_hold_s && !ifid_flush_s) begin
            num_inst_r <= sat_inc(num_inst_r);
        end else begin
            num_inst_r <= num_inst_r;
        end
    end

    assign o_num_inst = num_inst_r;
`else
    assign o_num_inst = 16'h0000;
`endif

endmodule
